cpu_mem_seq: RTL and testbench

- Memory access sequencer plus word-array storage; sits directly upstream of the 1-bit memory cells.
- Accepts one read or write request at a time through a valid/ready handshake.
- Latches the address into a memory address register (MAR), then drives the per-word set strobe (write) or enable strobe (read) for exactly one cycle, and returns a response through a valid/ready handshake.
- The storage models DEPTH x DATA_W memory cells; the strobe outputs are exported so the cell-level timing can be checked.

---
 rtl/cpu_mem_seq.sv | 162 ++++++++++++++++
 tb/tb_cpu_mem_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_seq.sv
`timescale 1ns/1ps
// cpu_mem_seq: single-request memory access sequencer in front of a
// DEPTH x DATA_W array of 1-bit memory cells. A request is latched into
// the memory address register, the addressed word is strobed for one cycle
// (set for writes, enable for reads), and a response is returned through a
// valid/ready handshake. The per-word strobes are exported so cell-level
// timing can be observed.
module cpu_mem_seq #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mar,
  output logic [DEPTH-1:0]  cell_s,
  output logic [DEPTH-1:0]  cell_e
);

  // Sequencer phases. SET and ENABLE each last exactly one cycle, which is
  // what guarantees the single-cycle strobe pulses.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SET,
    ST_ENABLE,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;   // captured request address
  logic                we_q,    we_d;     // captured request direction
  logic [DATA_W-1:0]   wdata_q, wdata_d;  // captured write data
  logic [ADDR_W-1:0]   mar_q,   mar_d;    // memory address register
  logic [DATA_W-1:0]   rdata_q, rdata_d;  // response data, held through RESP

  logic [DATA_W-1:0]   mem_q [DEPTH];     // the word array (memory cells)
  logic                mem_we;
  logic [DEPTH-1:0]    mar_onehot;

  // Next-state and datapath next values; every decision is taken from
  // registered state so no input reaches an output combinationally.
  // NOTE: each _d gets its hold value first, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    mar_d   = mar_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        mar_d   = addr_q;
        state_d = we_q ? ST_SET : ST_ENABLE;
      end
      ST_SET: begin
        rdata_d = '0;
        state_d = ST_RESP;
      end
      ST_ENABLE: begin
        rdata_d = mem_q[mar_q];
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // A request arriving together with rsp_ready is not taken here;
        // it can only be accepted from IDLE on a later edge.
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any transaction in flight.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mar_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      mar_q   <= mar_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_we = (state_q == ST_SET);

  // Word array: written only during SET, cleared by reset. A write whose
  // SET cycle is interrupted by reset is therefore lost.
  // NOTE: this array is reset on purpose because the cells must read as
  // zero after reset; that rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mar_q] <= wdata_q;
    end
  end

  // Strobes and handshake outputs decoded from registered state only.
  always_comb begin
    mar_onehot = '0;
    mar_onehot[mar_q] = 1'b1;
  end

  assign cell_s    = (state_q == ST_SET)    ? mar_onehot : '0;
  assign cell_e    = (state_q == ST_ENABLE) ? mar_onehot : '0;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign mar       = mar_q;

`ifndef SYNTHESIS
  // Set and enable strobes never overlap.
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !((|cell_s) && (|cell_e)));

  // Each strobe is one-hot or zero.
  a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(cell_s) && $onehot0(cell_e));

  // Each strobe pulse lasts a single cycle.
  a_set_pulse: assert property (@(posedge clk) disable iff (rst)
    (|cell_s) |=> (cell_s == '0));
  a_enable_pulse: assert property (@(posedge clk) disable iff (rst)
    (|cell_e) |=> (cell_e == '0));

  // A stalled response holds its data.
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

  // No request is taken while busy.
  a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
    req_ready == (state_q == ST_IDLE));
`endif

endmodule

// File: tb/tb_cpu_mem_seq.sv
`timescale 1ns/1ps
// Directed bench for cpu_mem_seq: a table of read/write transactions with
// hand-computed results, plus sequences for response stall, strobe timing
// and reset during a write.
module tb_cpu_mem_seq;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mar;
  logic [DEPTH-1:0]  cell_s;
  logic [DEPTH-1:0]  cell_e;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  cpu_mem_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mar       (mar),
    .cell_s    (cell_s),
    .cell_e    (cell_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction with rsp_ready held high. Called #1 after a rising
  // edge; returns #1 after the edge that retires the response.
  // lat = rising edges from acceptance until rsp_valid is seen.
  // s_cnt/e_cnt = cycles carrying the correct one-hot strobe; any wrong
  // nonzero strobe adds 100.
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd,
                         output logic [DATA_W-1:0] rd, output int lat,
                         output int s_cnt, output int e_cnt, output int acc_cyc);
    logic [DEPTH-1:0] oh;
    int n;
    oh = '0;
    oh[addr] = 1'b1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    lat = 0; s_cnt = 0; e_cnt = 0;
    while (!rsp_valid && lat < 20) begin
      if (cell_s == oh) s_cnt++; else if (cell_s != '0) s_cnt += 100;
      if (cell_e == oh) e_cnt++; else if (cell_e != '0) e_cnt += 100;
      @(posedge clk); #1; lat++;
    end
    if (cell_s != '0) s_cnt += 100;
    if (cell_e != '0) e_cnt += 100;
    rd = rsp_rdata;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [DATA_W-1:0] rd;
    int lat, s_cnt, e_cnt, acc, prev_acc, n, seen;
    logic [DEPTH-1:0] oh9;

    vecs[0]  = '{1'b0, 4'd5,  8'h00, 8'h00};  // read of cleared memory
    vecs[1]  = '{1'b1, 4'd3,  8'hA5, 8'h00};
    vecs[2]  = '{1'b0, 4'd3,  8'h00, 8'hA5};
    vecs[3]  = '{1'b1, 4'd0,  8'h11, 8'h00};
    vecs[4]  = '{1'b1, 4'd15, 8'hEE, 8'h00};
    vecs[5]  = '{1'b0, 4'd0,  8'h00, 8'h11};
    vecs[6]  = '{1'b0, 4'd15, 8'h00, 8'hEE};
    vecs[7]  = '{1'b1, 4'd13, 8'h5A, 8'h00};
    vecs[8]  = '{1'b1, 4'd12, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, 4'd12, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 4'd12, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 4'd13, 8'h00, 8'h5A};

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_mar",       32'(mar),       32'd0);
    check("reset_cell_s",    32'(cell_s),    32'd0);
    check("reset_cell_e",    32'(cell_e),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven transactions
    prev_acc = 0;
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, s_cnt, e_cnt, acc);
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_set_pulses", i), 32'(s_cnt), vecs[i].we ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_enable_pulses", i), 32'(e_cnt), vecs[i].we ? 32'd0 : 32'd1);
      if (i == 4) begin
        check("back_to_back_spacing", 32'(acc - prev_acc), 32'd4);
        check("mar_after_addr15", 32'(mar), 32'hF);
      end
      prev_acc = acc;
    end

    // Response stall on a read of addr 7, with a competing request held
    run_txn(1'b1, 4'd7, 8'h77, rd, lat, s_cnt, e_cnt, acc);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 4'd2; req_wdata = 8'h99;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("stall_reach_resp", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_rsp_rdata", k), 32'(rsp_rdata), 32'h77);
      check($sformatf("stall%0d_req_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stall_release_req_ready", 32'(req_ready), 32'd1);
    check("stall_release_mar", 32'(mar), 32'd7);
    // The held request is accepted on the following IDLE edge.
    @(posedge clk); #1;
    check("held_req_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("held_req_mar", 32'(mar), 32'd2);
    @(posedge clk); #1;
    run_txn(1'b0, 4'd2, 8'h00, rd, lat, s_cnt, e_cnt, acc);
    check("held_req_readback", 32'(rd), 32'h99);

    // Reset asserted mid-cycle during SET of a write to addr 9
    oh9 = '0;
    oh9[9] = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'h3C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_set_strobe_before", 32'(cell_s), 32'(oh9));
    #2;
    rst = 1'b1;
    #1;
    check("rst_in_set_cell_s", 32'(cell_s), 32'd0);
    check("rst_in_set_cell_e", 32'(cell_e), 32'd0);
    check("rst_in_set_req_ready", 32'(req_ready), 32'd1);
    check("rst_in_set_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_in_set_mar", 32'(mar), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check("rst_in_set_no_response", 32'(seen), 32'd0);
    run_txn(1'b0, 4'd9, 8'h00, rd, lat, s_cnt, e_cnt, acc);
    check("rst_in_set_write_lost", 32'(rd), 32'h00);
    check("rst_in_set_read_latency", 32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
